// File: rtl/data_stream_dist_aes_rf_if.sv
// Byte-stream AXI-Stream link (tdata/tvalid/tready/tlast) shared by the
// distributor's input and both of its outputs.
interface my_axis_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/data_stream_dist_aes_rf.sv
// 1:2 receive-side stream distributor: steers packets to the cipher path (m0)
// or the other path (m1), locking the route per packet, one-deep slice per output.
//
// state | meaning
// IDLE  | between packets; route follows wm/en combinationally
// BUSY  | mid-packet; route frozen to the value latched on the first beat
module data_stream_dist_aes_rf #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           wm,
  my_axis_if.slave             s_axis,
  my_axis_if.master            m0_axis,
  my_axis_if.master            m1_axis,
  output logic                 busy,
  output logic                 route,
  output logic [CNT_WIDTH-1:0] pkt_cnt0,
  output logic [CNT_WIDTH-1:0] pkt_cnt1
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                state_q, state_d;
  logic                  route_q, route_d;
  logic                  sel_c0;
  logic                  req_route;
  logic                  eff_route;
  logic                  accept;
  logic [1:0]            m_rdy;
  logic [1:0]            ld_ok;
  logic [1:0]            load;
  logic [1:0]            v_q;
  logic [1:0]            l_q;
  logic [DATA_WIDTH-1:0] d_q [2];

  assign sel_c0    = (wm == 2'b01) || ((wm == 2'b00) && en);
  assign req_route = ~sel_c0;
  assign eff_route = (state_q == BUSY) ? route_q : req_route;

  assign m_rdy  = {m1_axis.tready, m0_axis.tready};
  assign ld_ok  = ~v_q | m_rdy;

  assign s_axis.tready = eff_route ? ld_ok[1] : ld_ok[0];
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign load          = {accept && eff_route, accept && !eff_route};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      IDLE: begin
        if (accept && !s_axis.tlast) begin
          state_d = BUSY;
          route_d = eff_route;
        end
      end
      BUSY: begin
        if (accept && s_axis.tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A load in the same cycle as a drain simply overwrites the departing beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      l_q <= '0;
      for (int i = 0; i < 2; i++) d_q[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load[i]) begin
          v_q[i] <= 1'b1;
          d_q[i] <= s_axis.tdata;
          l_q[i] <= s_axis.tlast;
        end else if (m_rdy[i] && v_q[i]) begin
          v_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (v_q[0] && m_rdy[0] && l_q[0]) pkt_cnt0 <= pkt_cnt0 + 1'b1;
      if (v_q[1] && m_rdy[1] && l_q[1]) pkt_cnt1 <= pkt_cnt1 + 1'b1;
    end
  end

  assign m0_axis.tvalid = v_q[0];
  assign m0_axis.tdata  = d_q[0];
  assign m0_axis.tlast  = l_q[0];
  assign m1_axis.tvalid = v_q[1];
  assign m1_axis.tdata  = d_q[1];
  assign m1_axis.tlast  = l_q[1];

  assign busy  = (state_q == BUSY);
  assign route = eff_route;

endmodule

// File: tb/tb_data_stream_dist_aes_rf.sv
// Directed bench for data_stream_dist_aes_rf: routing, per-packet lock,
// back-pressure, single-beat packets and asynchronous reset mid-packet.
module tb_data_stream_dist_aes_rf;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  wm;
  logic        busy;
  logic        route;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;

  int n_run  = 0;
  int n_fail = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];

  my_axis_if #(.DATA_WIDTH(8)) s_if ();
  my_axis_if #(.DATA_WIDTH(8)) m0_if ();
  my_axis_if #(.DATA_WIDTH(8)) m1_if ();

  data_stream_dist_aes_rf #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .wm       (wm),
    .s_axis   (s_if),
    .m0_axis  (m0_if),
    .m1_axis  (m1_if),
    .busy     (busy),
    .route    (route),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  always #5 clk = ~clk;

  // Inputs only change just after posedge, so a handshake seen here completes at the next posedge.
  always @(negedge clk) begin
    if (!rst) begin
      if (m0_if.tvalid && m0_if.tready) q0.push_back({m0_if.tlast, m0_if.tdata});
      if (m1_if.tvalid && m1_if.tready) q1.push_back({m1_if.tlast, m1_if.tdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    int n = 0;
    s_if.tdata  = d;
    s_if.tlast  = l;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    while (!s_if.tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("send_timeout", {31'd0, s_if.tready}, 32'd1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop(input string tag, input int ch, input logic [8:0] exp);
    logic [9:0] got;
    if (ch == 0) got = (q0.size() == 0) ? 10'h3FF : {1'b0, q0.pop_front()};
    else         got = (q1.size() == 0) ? 10'h3FF : {1'b0, q1.pop_front()};
    chk(tag, {22'd0, got}, {23'd0, exp});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    en           = 1'b0;
    wm           = 2'b01;
    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    s_if.tlast   = 1'b0;
    m0_if.tready = 1'b1;
    m1_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_m0_valid", {31'd0, m0_if.tvalid}, 32'd0);
    chk("rst_m1_valid", {31'd0, m1_if.tvalid}, 32'd0);
    chk("rst_s_ready",  {31'd0, s_if.tready},  32'd1);
    chk("rst_busy",     {31'd0, busy},         32'd0);
    chk("rst_cnt0",     {16'd0, pkt_cnt0},     32'd0);
    chk("rst_cnt1",     {16'd0, pkt_cnt1},     32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // wm=01: 4-beat packet to m0, 1-cycle latency
    for (int i = 0; i < 4; i++) begin
      send(8'hA0 + 8'(i), (i == 3));
      chk("t1_lat_valid", {31'd0, m0_if.tvalid}, 32'd1);
      chk("t1_lat_data",  {24'd0, m0_if.tdata},  32'hA0 + i);
      chk("t1_lat_last",  {31'd0, m0_if.tlast},  (i == 3) ? 32'd1 : 32'd0);
      chk("t1_busy",      {31'd0, busy},         (i == 3) ? 32'd0 : 32'd1);
    end
    drain();
    for (int i = 0; i < 4; i++) pop("t1_m0_beat", 0, {(i == 3), 8'hA0 + 8'(i)});
    chk("t1_m1_empty", q1.size(), 32'd0);
    chk("t1_cnt0", {16'd0, pkt_cnt0}, 32'd1);
    chk("t1_cnt1", {16'd0, pkt_cnt1}, 32'd0);

    // wm=00: en drops mid-packet, route stays locked
    wm = 2'b00;
    en = 1'b1;
    #1;
    chk("t2_idle_busy", {31'd0, busy}, 32'd0);
    send(8'hB0, 1'b0);
    chk("t2_busy_b0", {31'd0, busy}, 32'd1);
    en = 1'b0;
    #1;
    chk("t2_route_locked", {31'd0, route}, 32'd0);
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b1);
    chk("t2_busy_end", {31'd0, busy},  32'd0);
    chk("t2_route_req", {31'd0, route}, 32'd1);
    send(8'hC0, 1'b0);
    chk("t2_busy_c0",  {31'd0, busy},  32'd1);
    chk("t2_route_c0", {31'd0, route}, 32'd1);
    send(8'hC1, 1'b1);
    drain();
    pop("t2_m0_b0", 0, {1'b0, 8'hB0});
    pop("t2_m0_b1", 0, {1'b0, 8'hB1});
    pop("t2_m0_b2", 0, {1'b1, 8'hB2});
    pop("t2_m1_c0", 1, {1'b0, 8'hC0});
    pop("t2_m1_c1", 1, {1'b1, 8'hC1});
    chk("t2_cnt0", {16'd0, pkt_cnt0}, 32'd2);
    chk("t2_cnt1", {16'd0, pkt_cnt1}, 32'd1);

    // wm=10 / wm=11 ignore en
    en = 1'b1;
    wm = 2'b10;
    send(8'hD0, 1'b0);
    send(8'hD1, 1'b1);
    wm = 2'b11;
    send(8'hE0, 1'b1);
    drain();
    pop("t3_m1_d0", 1, {1'b0, 8'hD0});
    pop("t3_m1_d1", 1, {1'b1, 8'hD1});
    pop("t3_m1_e0", 1, {1'b1, 8'hE0});
    chk("t3_m0_empty", q0.size(), 32'd0);
    chk("t3_cnt0", {16'd0, pkt_cnt0}, 32'd2);
    chk("t3_cnt1", {16'd0, pkt_cnt1}, 32'd3);

    // m0 back-pressure: slice fills, input stalls, data held stable
    wm = 2'b01;
    m0_if.tready = 1'b0;
    send(8'hF0, 1'b0);
    s_if.tdata  = 8'hF1;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_s_stall",  {31'd0, s_if.tready},   32'd0);
      chk("t4_m0_valid", {31'd0, m0_if.tvalid},  32'd1);
      chk("t4_m0_hold",  {24'd0, m0_if.tdata},   32'hF0);
      chk("t4_m0_last",  {31'd0, m0_if.tlast},   32'd0);
    end
    @(posedge clk);
    #1;
    m0_if.tready = 1'b1;
    send(8'hF1, 1'b0);
    send(8'hF2, 1'b1);
    drain();
    pop("t4_m0_f0", 0, {1'b0, 8'hF0});
    pop("t4_m0_f1", 0, {1'b0, 8'hF1});
    pop("t4_m0_f2", 0, {1'b1, 8'hF2});
    chk("t4_m0_nodup", q0.size(), 32'd0);
    chk("t4_cnt0", {16'd0, pkt_cnt0}, 32'd3);

    // alternating single-beat packets
    for (int i = 0; i < 8; i++) begin
      wm = (i % 2 == 0) ? 2'b01 : 2'b10;
      send(8'h10 + 8'(i), 1'b1);
      chk("t5_busy", {31'd0, busy}, 32'd0);
    end
    drain();
    for (int i = 0; i < 4; i++) begin
      pop("t5_m0", 0, {1'b1, 8'h10 + 8'(2 * i)});
      pop("t5_m1", 1, {1'b1, 8'h11 + 8'(2 * i)});
    end
    chk("t5_cnt0", {16'd0, pkt_cnt0}, 32'd7);
    chk("t5_cnt1", {16'd0, pkt_cnt1}, 32'd7);

    // async reset mid-packet with a stalled beat in m0
    wm = 2'b01;
    m0_if.tready = 1'b0;
    send(8'h5A, 1'b0);
    wm = 2'b10;
    #1;
    chk("t6_pre_busy",  {31'd0, busy},         32'd1);
    chk("t6_pre_route", {31'd0, route},        32'd0);
    chk("t6_pre_valid", {31'd0, m0_if.tvalid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_m0_valid", {31'd0, m0_if.tvalid}, 32'd0);
    chk("t6_cnt0",     {16'd0, pkt_cnt0},     32'd0);
    chk("t6_cnt1",     {16'd0, pkt_cnt1},     32'd0);
    chk("t6_busy",     {31'd0, busy},         32'd0);
    chk("t6_route",    {31'd0, route},        32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m0_if.tready = 1'b1;
    q0.delete();
    q1.delete();
    send(8'h77, 1'b1);
    drain();
    pop("t6_m1_new", 1, {1'b1, 8'h77});
    chk("t6_m0_empty", q0.size(), 32'd0);
    chk("t6_cnt1_new", {16'd0, pkt_cnt1}, 32'd1);
    chk("t6_cnt0_new", {16'd0, pkt_cnt0}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
